// File: rtl/multicycle_memory.sv
// Word-addressed memory with a fixed access latency behind a ready/valid handshake.
// One request in flight; completion is signalled with a single-cycle pulse.
module multicycle_memory #(
  parameter int DEPTH   = 16384,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_dout,
  output logic        is_ready,
  output logic        is_output_valid,
  output logic        is_write_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic          op_write;
  logic          commit;

  logic [31:0] mem [DEPTH];

  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  // Reset forces IDLE asynchronously, so an in-flight write never commits.
  assign commit = (state == WAIT) && (cnt == 4'd0) && op_write;

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      idx      <= '0;
      wdata    <= 32'd0;
      op_write <= 1'b0;
      mem_dout <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            state    <= WAIT;
            cnt      <= CNT_INIT;
            idx      <= addr[AW+1:2];
            wdata    <= din;
            op_write <= mem_write;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            if (!op_write) begin
              mem_dout <= mem[idx];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign is_ready        = (state == IDLE);
  assign is_output_valid = (state == RESP) && !op_write;
  assign is_write_done   = (state == RESP) && op_write;

endmodule
